// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and width helpers for the MAC neuron node
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_HSIG  = 2'd2,
        ACT_LRELU = 2'd3
    } act_sel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ACT   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Full product width plus enough headroom that n_in terms can never overflow
    function automatic int acc_w(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

endpackage

// File: rtl/mac_node_if.sv
// rtl/mac_node_if.sv - control, term-input and result handshake bundle of mac_node
interface mac_node_if #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 64
);
    import nn_pkg::*;

    logic                           start;
    logic [$clog2(N_IN+1)-1:0]      n_terms;
    act_sel_e                       act_sel;
    logic                           busy;

    logic                           in_valid;
    logic                           in_ready;
    logic signed [WIDTH-1:0]        coef_in;
    logic signed [WIDTH-1:0]        data_in;

    logic                           out_valid;
    logic                           out_ready;
    logic signed [WIDTH-1:0]        node_out;
    logic                           sat_flag;

    modport master (
        output start, n_terms, act_sel, in_valid, coef_in, data_in, out_ready,
        input  busy, in_ready, out_valid, node_out, sat_flag
    );

    modport slave (
        input  start, n_terms, act_sel, in_valid, coef_in, data_in, out_ready,
        output busy, in_ready, out_valid, node_out, sat_flag
    );

endinterface

// File: rtl/nn_activation.sv
// rtl/nn_activation.sv - rescale accumulator to WIDTH with saturation, then apply activation
module nn_activation
    import nn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 38
) (
    input  logic signed [ACC_W-1:0] accumulator,
    input  act_sel_e                act_sel,
    output logic signed [WIDTH-1:0] value,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0]   HALF  = (WIDTH+1)'(2 ** (FRAC - 1));
    localparam logic signed [WIDTH:0]   ONE   = (WIDTH+1)'(2 ** FRAC);

    logic signed [ACC_W-1:0] shifted;
    logic signed [WIDTH-1:0] clipped;
    logic signed [WIDTH:0]   hs;

    always_comb begin
        shifted = accumulator >>> FRAC;
        sat     = 1'b0;
        clipped = shifted[WIDTH-1:0];
        if (shifted > MAX_V) begin
            clipped = {1'b0, {(WIDTH-1){1'b1}}};
            sat     = 1'b1;
        end else if (shifted < MIN_V) begin
            clipped = {1'b1, {(WIDTH-1){1'b0}}};
            sat     = 1'b1;
        end

        // One extra bit so x/4 + 0.5 cannot wrap before the clamp
        hs = (WIDTH+1)'(clipped >>> 2) + HALF;

        value = clipped;
        case (act_sel)
            ACT_ID:    value = clipped;
            ACT_RELU:  value = (clipped < 0) ? '0 : clipped;
            ACT_HSIG: begin
                if (hs < 0)        value = '0;
                else if (hs > ONE) value = ONE[WIDTH-1:0];
                else               value = hs[WIDTH-1:0];
            end
            ACT_LRELU: value = (clipped < 0) ? (clipped >>> 3) : clipped;
            default:   value = clipped;
        endcase
    end

endmodule

// File: rtl/mac_node.sv
// rtl/mac_node.sv - streaming dot-product neuron: accumulate n_terms products, activate, hand off
module mac_node
    import nn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int N_IN  = 64
) (
    input  logic     clk,
    input  logic     n_rst,
    mac_node_if.slave bus
);

    localparam int ACC_W = acc_w(WIDTH, N_IN);
    localparam int CW    = $clog2(N_IN + 1);
    localparam logic [CW-1:0] N_MAX = CW'(N_IN);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           n_terms_q, n_terms_d;
    act_sel_e                act_q, act_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    sat_q, sat_d;
    logic                    ov_q, ov_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   act_value;
    logic                      act_sat;

    assign prod = (2*WIDTH)'(bus.coef_in) * (2*WIDTH)'(bus.data_in);

    nn_activation #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_act (
        .accumulator (acc_q),
        .act_sel     (act_q),
        .value       (act_value),
        .sat         (act_sat)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            n_terms_q <= '0;
            act_q     <= ACT_ID;
            out_q     <= '0;
            sat_q     <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            n_terms_q <= n_terms_d;
            act_q     <= act_d;
            out_q     <= out_d;
            sat_q     <= sat_d;
            ov_q      <= ov_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        n_terms_d = n_terms_q;
        act_d     = act_q;
        out_d     = out_q;
        sat_d     = sat_q;
        ov_d      = ov_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.n_terms != '0) && (bus.n_terms <= N_MAX)) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    n_terms_d = bus.n_terms;
                    act_d     = bus.act_sel;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = acc_q + ACC_W'(prod);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == n_terms_q) state_d = S_ACT;
                end
            end
            S_ACT: begin
                out_d   = act_value;
                sat_d   = act_sat;
                ov_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Result stays parked until the consumer takes it
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = ov_q;
    assign bus.node_out  = out_q;
    assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_mac_node.sv
// tb/tb_mac_node.sv - directed self-checking bench for mac_node
module tb_mac_node;
    import nn_pkg::*;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int N_IN  = 64;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    mac_node_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();

    mac_node #(.WIDTH(WIDTH), .FRAC(FRAC), .N_IN(N_IN)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start     = 1'b0;
        bus.n_terms   = '0;
        bus.act_sel   = ACT_ID;
        bus.in_valid  = 1'b0;
        bus.coef_in   = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic start_op(input int n, input act_sel_e a);
        bus.start   = 1'b1;
        bus.n_terms = 7'(n);
        bus.act_sel = a;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic beat(input logic [15:0] c, input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.coef_in  = c;
        bus.data_in  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic pop;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input int n, input act_sel_e a, input logic [15:0] c[4],
                          input logic [15:0] d[4], output int cyc);
        start_op(n, a);
        for (int i = 0; i < n; i++) beat(c[i], d[i]);
        wait_out(cyc);
    endtask

    task automatic test_reset;
        idle_inputs();
        n_rst = 1'b0;
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.node_out !== 16'h0000) begin bad++; $display("FAIL rst_node_out got=%h exp=0000", bus.node_out); end
        total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b exp=0", bus.sat_flag); end
        #2 n_rst = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int cyc;
        run_op(3, ACT_ID, '{16'h0100, 16'h0100, 16'h0100, 16'h0}, '{16'h0100, 16'h0200, 16'hFF00, 16'h0}, cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL basic_latency got=%0d exp=1", cyc); end
        total++; if (bus.node_out !== 16'h0200) begin bad++; $display("FAIL basic_out got=%h exp=0200", bus.node_out); end
        total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b exp=0", bus.sat_flag); end
        total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_done_flags got busy=%b rdy=%b exp busy=1 rdy=0", bus.busy, bus.in_ready); end
        pop();
        total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL basic_pop got ov=%b busy=%b exp 0 0", bus.out_valid, bus.busy); end
        tick();
        total++; if (bus.node_out !== 16'h0200) begin bad++; $display("FAIL basic_retain got=%h exp=0200", bus.node_out); end
    endtask

    task automatic test_act;
        int cyc;
        run_op(1, ACT_RELU, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'hFE00, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h0000 || cyc !== 1) begin bad++; $display("FAIL relu_neg got=%h cyc=%0d exp=0000 cyc=1", bus.node_out, cyc); end
        pop();
        run_op(1, ACT_LRELU, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'hFE00, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'hFFC0) begin bad++; $display("FAIL lrelu_neg got=%h exp=ffc0", bus.node_out); end
        pop();
        run_op(1, ACT_RELU, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'h0300, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h0300) begin bad++; $display("FAIL relu_pos got=%h exp=0300", bus.node_out); end
        pop();
    endtask

    task automatic test_sat;
        int cyc;
        run_op(4, ACT_ID, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, cyc);
        total++; if (bus.node_out !== 16'h7FFF || bus.sat_flag !== 1'b1) begin bad++; $display("FAIL sat_pos got=%h sat=%b exp=7fff sat=1", bus.node_out, bus.sat_flag); end
        pop();
        run_op(4, ACT_ID, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, cyc);
        total++; if (bus.node_out !== 16'h8000 || bus.sat_flag !== 1'b1) begin bad++; $display("FAIL sat_neg got=%h sat=%b exp=8000 sat=1", bus.node_out, bus.sat_flag); end
        pop();
    endtask

    task automatic test_hsig;
        int cyc;
        run_op(1, ACT_HSIG, '{16'h0000, 16'h0, 16'h0, 16'h0}, '{16'h0000, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h0080) begin bad++; $display("FAIL hsig_zero got=%h exp=0080", bus.node_out); end
        pop();
        run_op(1, ACT_HSIG, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'h0400, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h0100 || bus.sat_flag !== 1'b0) begin bad++; $display("FAIL hsig_hi got=%h sat=%b exp=0100 sat=0", bus.node_out, bus.sat_flag); end
        pop();
        run_op(1, ACT_HSIG, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'hFC00, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h0000) begin bad++; $display("FAIL hsig_lo got=%h exp=0000", bus.node_out); end
        pop();
        run_op(1, ACT_HSIG, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'h0100, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h00C0) begin bad++; $display("FAIL hsig_mid got=%h exp=00c0", bus.node_out); end
        pop();
    endtask

    task automatic test_bad_start;
        start_op(0, ACT_ID);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_zero got busy=%b exp=0", bus.busy); end
        start_op(65, ACT_ID);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_over got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_gaps_hold;
        int cyc;
        logic [15:0] dv[4];
        dv = '{16'h0100, 16'h0200, 16'h0300, 16'hFF00};
        start_op(4, ACT_ID);
        for (int i = 0; i < 4; i++) begin
            beat(16'h0100, dv[i]);
            if (i < 3) begin
                // start pulsed mid-accumulation with a smaller count must not cut the op short
                bus.start   = 1'b1;
                bus.n_terms = 7'd1;
                tick();
                bus.start   = 1'b0;
                total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL gap_state got rdy=%b ov=%b exp rdy=1 ov=0", bus.in_ready, bus.out_valid); end
            end
        end
        wait_out(cyc);
        total++; if (cyc !== 1 || bus.node_out !== 16'h0500) begin bad++; $display("FAIL gap_result got=%h cyc=%0d exp=0500 cyc=1", bus.node_out, cyc); end
        for (int i = 0; i < 5; i++) begin
            bus.start   = (i == 2);
            bus.n_terms = 7'd1;
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.node_out !== 16'h0500) begin bad++; $display("FAIL hold_%0d got ov=%b out=%h exp ov=1 out=0500", i, bus.out_valid, bus.node_out); end
        end
        bus.start = 1'b0;
        pop();
        tick();
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL done_start_ignored got busy=%b ov=%b exp 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        start_op(4, ACT_ID);
        beat(16'h0100, 16'h0700);
        beat(16'h0100, 16'h0700);
        n_rst = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got busy=%b rdy=%b ov=%b exp 0 0 0", bus.busy, bus.in_ready, bus.out_valid); end
        total++; if (bus.node_out !== 16'h0000 || bus.sat_flag !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%h sat=%b exp=0000 sat=0", bus.node_out, bus.sat_flag); end
        #2 n_rst = 1'b1;
        tick();
        run_op(1, ACT_ID, '{16'h0100, 16'h0, 16'h0, 16'h0}, '{16'h0100, 16'h0, 16'h0, 16'h0}, cyc);
        total++; if (bus.node_out !== 16'h0100 || cyc !== 1) begin bad++; $display("FAIL post_rst got=%h cyc=%0d exp=0100 cyc=1", bus.node_out, cyc); end
        pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_act();
        test_sat();
        test_hsig();
        test_bad_start();
        test_gaps_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_node.md
MAC_NODE -- requirements
Module: mac_node

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed two's-complement data/coef/output width.
REQ-002 SHALL have parameter FRAC, default 8, fractional bits of fixed-point format (Q(WIDTH-FRAC).FRAC).
REQ-003 SHALL have parameter N_IN, default 64, maximum terms per dot product.
REQ-004 SHALL have clk input 1 rising-edge clock. Reset n_rst, asynchronous, active-low; clock clk.
REQ-005 SHALL have n_rst input 1 asynchronous active-low reset.
REQ-006 SHALL have start input 1, begins an operation (IDLE only).
REQ-007 SHALL have n_terms input $clog2(N_IN+1), term count, sampled with start.
REQ-008 SHALL have act_sel input 2, activation mode, sampled with start.
REQ-009 SHALL have in_valid input 1, coef_in/data_in valid.
REQ-010 SHALL have in_ready output 1, node accepts a term this cycle.
REQ-011 SHALL have coef_in input WIDTH, signed weight.
REQ-012 SHALL have data_in input WIDTH, signed activation input.
REQ-013 SHALL have out_valid output 1, node_out valid.
REQ-014 SHALL have out_ready input 1, consumer accepts node_out.
REQ-015 SHALL have node_out output WIDTH, signed activated result.
REQ-016 SHALL have sat_flag output 1, result was saturated; qualified by out_valid.
REQ-017 SHALL have busy output 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, ACCUM, ACT, DONE.
REQ-019 IDLE: start=1 with n_terms in 1..N_IN SHALL clear accumulator and term counter, latch n_terms/act_sel, go to ACCUM; n_terms=0 or >N_IN SHALL be ignored (stay IDLE).
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 ACCUM: in_ready=1; each cycle with in_valid=1 SHALL add full 2*WIDTH signed product coef_in*data_in to accumulator of width ACC_W = 2*WIDTH + $clog2(N_IN); no overflow possible.
REQ-022 in_valid=0 cycles SHALL leave accumulator and counter unchanged (gaps allowed).
REQ-023 Acceptance of beat number n_terms SHALL move to ACT; in_ready=0 in all other states.
REQ-024 ACT (one cycle): accumulator arithmetic-shifted right by FRAC (truncate toward -inf), saturated to WIDTH signed, then activated; result and sat_flag registered, out_valid=1 on the edge ending ACT, go to DONE.
REQ-025 Latency: out_valid rises exactly 1 cycle after last accepted beat.
REQ-026 act_sel 0 identity; 1 ReLU (negative->0); 2 hard-sigmoid y=clamp(x>>>2 + 0.5, 0, 1.0); 3 leaky ReLU (negative->x>>>3).
REQ-027 sat_flag SHALL be 1 iff pre-activation saturation clipped the value (hard-sigmoid clamp does not set it).
REQ-028 DONE: out_valid, node_out, sat_flag held stable until out_ready=1; then out_valid cleared, go to IDLE.
REQ-029 node_out SHALL retain last value in IDLE until next result.

Reset
REQ-030 n_rst=0 SHALL asynchronously force IDLE, accumulator=0, counter=0, node_out=0, sat_flag=0, out_valid=0, in_ready=0, busy=0, at any state including mid-ACCUM; partial sums discarded.

Structure
REQ-031 Package nn_pkg SHALL hold act_sel enum (ACT_ID, ACT_RELU, ACT_HSIG, ACT_LRELU), state enum, and ACC_W width function.
REQ-032 Combinational sub-module nn_activation SHALL perform shift/saturate/activation (inputs accumulator, act_sel; outputs value, sat).

Verification (WIDTH=16, FRAC=8, N_IN=64)
REQ-033 n_terms=3, act 0, coef 0x0100 x3, data 0x0100/0x0200/0xFF00 back-to-back -> node_out=0x0200, sat_flag=0, out_valid 1 cycle after 3rd beat.
REQ-034 n_terms=1, coef 0x0100, data 0xFE00: act 1 -> 0x0000; act 3 -> 0xFFC0.
REQ-035 n_terms=4, coef=data=0x7FFF, act 0 -> node_out=0x7FFF, sat_flag=1; same with data 0x8000 -> 0x8000, sat_flag=1.
REQ-036 act 2: sum 0 -> 0x0080; sum 0x0400 -> 0x0100; sum 0xFC00 -> 0x0000.
REQ-037 n_terms=4 with in_valid gaps; out_ready low 5 cycles; start pulsed in DONE -> result unaffected, out_valid held, start ignored, IDLE after out_ready.
REQ-038 n_rst low after 2 of 4 beats -> all outputs 0 immediately; next op n_terms=1 (0x0100*0x0100) -> 0x0100.
